// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction-memory loader: memory geometry and
// the 3-bit loader FSM state encoding.
package inst_loader_pkg;

  localparam int IMEM_ADDR_W = 9;
  localparam int IMEM_DEPTH  = 512;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_LEN_LO = 3'd1;
  localparam state_t S_LEN_HI = 3'd2;
  localparam state_t S_DATA   = 3'd3;
  localparam state_t S_WRITE  = 3'd4;
  localparam state_t S_CHK    = 3'd5;
  localparam state_t S_DONE   = 3'd6;
  localparam state_t S_ERR    = 3'd7;

endpackage

// File: rtl/inst_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The loader uses the slave view; the byte source / memory side uses master.
interface inst_loader_if
  import inst_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              im_wen;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, im_wen, im_addr, im_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, im_wen, im_addr, im_wdata
  );
endinterface

// File: rtl/inst_loader_word_packer.sv
// Little-endian byte-to-word assembler: bytes shift in from the top so the
// first byte of a group ends up in bits [7:0] after four loads.
module inst_loader_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        last
);

  logic [1:0] idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
      idx  <= '0;
    end else if (clr) begin
      word <= '0;
      idx  <= '0;
    end else if (load) begin
      word <= {byte_in, word[31:8]};
      idx  <= idx + 2'd1;
    end
  end

  assign last = (idx == 2'd3);

endmodule

// File: rtl/inst_loader.sv
// Loads a length-prefixed byte image into instruction memory and holds the CPU
// in reset until it completes. Optional trailing XOR check: INST_LOADER_CHECKSUM_EN.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  inst_loader_if.slave    bus,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            cpu_hold,
  output logic [ADDR_W:0] words_loaded
);

  state_t          state;
  state_t          next_state;
  logic [15:0]     len_q;
  logic [15:0]     len_next;
  logic [ADDR_W:0] wl_inc;
  logic            accept;
  logic            launch;
  logic            last_word;
  logic            pk_load;
  logic            pk_last;
  logic            im_wen_q;
  logic [31:0]     word;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]      csum;
`endif

  assign accept    = bus.in_valid && bus.in_ready;
  assign launch    = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign len_next  = {bus.in_data, len_q[7:0]};
  assign wl_inc    = words_loaded + 1'b1;
  assign last_word = (16'(wl_inc) == len_q);

  inst_loader_word_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .clr     (launch),
    .load    (pk_load),
    .byte_in (bus.in_data),
    .word    (word),
    .last    (pk_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) next_state = S_LEN_LO;
      S_LEN_LO: if (accept) next_state = S_LEN_HI;
      S_LEN_HI: begin
        if (accept) begin
          if (len_next == 16'd0)
`ifdef INST_LOADER_CHECKSUM_EN
            next_state = S_CHK;
`else
            next_state = S_DONE;
`endif
          else if (len_next > 16'(DEPTH)) next_state = S_ERR;
          else                            next_state = S_DATA;
        end
      end
      S_DATA: if (accept && pk_last) next_state = S_WRITE;
      S_WRITE: begin
        if (last_word)
`ifdef INST_LOADER_CHECKSUM_EN
          next_state = S_CHK;
`else
          next_state = S_DONE;
`endif
        else
          next_state = S_DATA;
      end
      S_CHK: begin
`ifdef INST_LOADER_CHECKSUM_EN
        if (accept) next_state = (bus.in_data == csum) ? S_DONE : S_ERR;
`else
        next_state = S_ERR;
`endif
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                   (state == S_DATA)   || (state == S_CHK);
    pk_load      = accept && (state == S_DATA);
  end

  // Status, counters and the registered write strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q        <= '0;
      words_loaded <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      cpu_hold     <= 1'b1;
      im_wen_q     <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      im_wen_q <= (next_state == S_WRITE);
      if (launch) begin
        words_loaded <= '0;
        busy         <= 1'b1;
        done         <= 1'b0;
        err          <= 1'b0;
        cpu_hold     <= 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
        csum         <= '0;
`endif
      end else begin
        if ((state == S_LEN_LO) && accept) len_q[7:0]  <= bus.in_data;
        if ((state == S_LEN_HI) && accept) len_q[15:8] <= bus.in_data;
        if (state == S_WRITE) words_loaded <= wl_inc;
`ifdef INST_LOADER_CHECKSUM_EN
        if (pk_load) csum <= csum ^ bus.in_data;
`endif
        if ((next_state == S_DONE) && (state != S_DONE)) begin
          done     <= 1'b1;
          busy     <= 1'b0;
          cpu_hold <= 1'b0;
        end
        if ((next_state == S_ERR) && (state != S_ERR)) begin
          err      <= 1'b1;
          busy     <= 1'b0;
          cpu_hold <= 1'b1;
        end
      end
    end
  end

  // Address is the pre-increment count, valid during the WRITE cycle
  assign bus.im_wen   = im_wen_q;
  assign bus.im_addr  = words_loaded[ADDR_W-1:0];
  assign bus.im_wdata = word;

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: directed byte images, expected memory
// writes queued at stimulus time and checked by an independent write monitor.
module tb_inst_loader;
  import inst_loader_pkg::*;

  localparam int ADDR_W = IMEM_ADDR_W;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            busy;
  logic            done;
  logic            err;
  logic            cpu_hold;
  logic [ADDR_W:0] words_loaded;

  inst_loader_if #(.ADDR_W(ADDR_W)) bus ();

  inst_loader #(.ADDR_W(ADDR_W), .DEPTH(IMEM_DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .cpu_hold     (cpu_hold),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  int         checks = 0;
  int         errors = 0;
  wr_t        exp_q[$];
  logic [7:0] frame[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  task automatic expect_wr(input int addr, input logic [31:0] data);
    wr_t e;
    e.addr = addr[ADDR_W-1:0];
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Write monitor: every im_wen pulse must match the head of the queue
  always @(negedge clk) begin
    wr_t e;
    if (!rst && bus.im_wen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%0d:%h required=none", bus.im_addr, bus.im_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.im_addr), 32'(e.addr));
        check("wr_data", bus.im_wdata, e.data);
        check("ready_in_write", 32'(bus.in_ready), 32'd0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      fail("accept_timeout");
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_frame(input int gap_max, input bit add_csum);
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    if (add_csum) begin
      for (int i = 2; i < frame.size(); i++) x ^= frame[i];
      frame.push_back(x);
    end
`else
    if (add_csum) begin end
`endif
    for (int i = 0; i < frame.size(); i++) begin
      if (gap_max > 0 && i > 0) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
      end
      send_byte(frame[i]);
    end
    bus.in_valid = 1'b0;
    frame.delete();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) fail("idle_timeout");
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_im_wen", 32'(bus.im_wen), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);

    // Two-word image, valid held high
    expect_wr(0, 32'h12345678);
    expect_wr(1, 32'hDEADBEEF);
    pulse_start();
    check("start_busy", 32'(busy), 32'd1);
    frame = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_frame(0, 1'b1);
    wait_idle();
    check("img2_done", 32'(done), 32'd1);
    check("img2_hold", 32'(cpu_hold), 32'd0);
    check("img2_words", 32'(words_loaded), 32'd2);
    check("img2_err", 32'(err), 32'd0);

    // Oversized length 513
    pulse_start();
    check("restart_done_clr", 32'(done), 32'd0);
    frame = '{8'h01, 8'h02};
    run_frame(0, 1'b0);
    wait_idle();
    check("big_err", 32'(err), 32'd1);
    check("big_hold", 32'(cpu_hold), 32'd1);
    check("big_done", 32'(done), 32'd0);
    check("big_words", 32'(words_loaded), 32'd0);

    // Empty image
    pulse_start();
    frame = '{8'h00, 8'h00};
    run_frame(0, 1'b1);
    wait_idle();
    check("len0_done", 32'(done), 32'd1);
    check("len0_err", 32'(err), 32'd0);
    check("len0_hold", 32'(cpu_hold), 32'd0);

    // Three words with random gaps on in_valid
    expect_wr(0, 32'h44332211);
    expect_wr(1, 32'h88776655);
    expect_wr(2, 32'hCCBBAA99);
    pulse_start();
    frame = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
              8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    run_frame(3, 1'b1);
    wait_idle();
    check("gap_done", 32'(done), 32'd1);
    check("gap_words", 32'(words_loaded), 32'd3);

    // Reset in the middle of the second word
    expect_wr(0, 32'hA4A3A2A1);
    pulse_start();
    frame = '{8'h02, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    run_frame(0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_words", 32'(words_loaded), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_hold", 32'(cpu_hold), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_ready", 32'(bus.in_ready), 32'd0);
    expect_wr(0, 32'h0A0B0C0D);
    pulse_start();
    frame = '{8'h01, 8'h00, 8'h0D, 8'h0C, 8'h0B, 8'h0A};
    run_frame(0, 1'b1);
    wait_idle();
    check("reload_done", 32'(done), 32'd1);
    check("reload_words", 32'(words_loaded), 32'd1);

`ifdef INST_LOADER_CHECKSUM_EN
    // Explicit check bytes: 01^02^04^08 = 0F
    expect_wr(0, 32'h08040201);
    pulse_start();
    frame = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
    run_frame(0, 1'b0);
    wait_idle();
    check("csum_ok_done", 32'(done), 32'd1);
    check("csum_ok_err", 32'(err), 32'd0);
    expect_wr(0, 32'h08040201);
    pulse_start();
    frame = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0E};
    run_frame(0, 1'b0);
    wait_idle();
    check("csum_bad_err", 32'(err), 32'd1);
    check("csum_bad_done", 32'(done), 32'd0);
    check("csum_bad_hold", 32'(cpu_hold), 32'd1);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
